mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares one single-port memory between the instruction-fetch port and the load/store data port of the CPU. This replaces the separate instruction and data memories with one unified memory. Each requester issues one transaction at a time with a req/ack handshake. The arbiter registers the winning request onto the memory port, waits a variable number of cycles for the memory's `mem_ready`, and returns the read data. A bounded timeout turns a stalled memory into an error acknowledge.

## Interface
- `ADDR_WIDTH`, default 32: address width of all ports.
- `DATA_WIDTH`, default 32: data width of all ports.
- `TIMEOUT`, default 255: maximum number of cycles the arbiter waits for `mem_ready` per transaction. Must be ≥1.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction-fetch request. The requester holds it, with `i_addr`, stable until `i_ack`.
- `i_addr` in ADDR_WIDTH: fetch address.
- `i_ack` out 1: one-cycle pulse that completes a fetch.
- `i_err` out 1: valid with `i_ack`. 1 means the fetch timed out.
- `i_rdata` out DATA_WIDTH: fetched word. Valid with `i_ack`; held until the next `i_ack`.
- `d_req` in 1: data request. The requester holds it, with `d_we`, `d_addr` and `d_wdata`, stable until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_WIDTH: data address.
- `d_wdata` in DATA_WIDTH: store data.
- `d_ack` out 1: one-cycle pulse that completes a data access.
- `d_err` out 1: valid with `d_ack`. 1 means the access timed out.
- `d_rdata` out DATA_WIDTH: load data. Updated only by a successful load; held otherwise.
- `mem_req` out 1: memory request, held high for the whole transaction.
- `mem_we` out 1: registered copy of the granted requester's write enable (always 0 for fetches).
- `mem_addr` out ADDR_WIDTH: registered copy of the granted requester's address.
- `mem_wdata` out DATA_WIDTH: registered copy of the granted requester's write data.
- `mem_ready` in 1: memory completion. Sampled only while `mem_req` is 1.
- `mem_rdata` in DATA_WIDTH: memory read data. Valid when `mem_ready` is 1.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **Grant in IDLE**
  - Only one eligible request: grant it.
  - Both eligible: grant the port not granted last, tracked by the `last_d` flag.
  - On grant: move to BUSY_x, load `mem_addr`, `mem_we` and `mem_wdata` from the granted port, set `mem_req` to 1, clear the timeout counter, update `last_d`.
- **Successful completion in BUSY_x**
  - Condition: `mem_ready` is 1.
  - Go to IDLE and drop `mem_req`.
  - Pulse `x_ack` with `x_err` = 0.
  - Capture `mem_rdata` into `x_rdata` unless the access is a store.
- **Timeout in BUSY_x**
  - Each busy cycle with `mem_ready` = 0 increments the counter.
  - When the counter reaches TIMEOUT-1 with no ready: go to IDLE, pulse `x_ack` with `x_err` = 1, leave `x_rdata` unchanged.
  - If `mem_ready` arrives in the same cycle as the timeout, ready wins and the access succeeds.
- **Eligibility**
  - In the cycle in which `x_ack` is high, a request from port x is masked. This prevents a stale `x_req` from being re-granted.
  - The other port may be granted in that same cycle.
- **Dropped request**
  - Deasserting `x_req` while BUSY_x has no effect: the transaction completes and the ack is still issued.
- **Reset**
  - All outputs go to 0 and the state goes to IDLE.
  - `last_d` goes to 1, so I wins the first tie.
  - Counter goes to 0.
  - Reset in mid-transaction drops `mem_req` immediately and produces no ack.

## Timing
- Cycle 0: IDLE samples `x_req`.
- Cycle 1: `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are registered high/valid.
- First `mem_ready` cycle k ≥ 1: `x_ack` is high in cycle k+1. Minimum latency is 2 cycles from request to ack.
- Timeout path: `mem_req` is high for cycles 1..TIMEOUT, and the error ack is high in cycle TIMEOUT+1.
- Back-to-back (I and D requesting continuously): a memory turnaround of 1 IDLE cycle between transactions, and grants alternate I, D, I, D, ...
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `mem_arbiter_pkg`:
  - state encoding: ARB_IDLE = 2'd0, ARB_BUSY_I = 2'd1, ARB_BUSY_D = 2'd2;
  - port-select constants: ARB_PORT_I = 1'b0, ARB_PORT_D = 1'b1.
- Sub-module `arb_timeout`:
  - counter sized to hold TIMEOUT, with clear, increment and expired signals;
  - same clock and reset as `mem_arbiter`.

## Test plan
- **Single fetch.** Reset. Stimulus: `i_req` = 1, `i_addr` = 0x10. Memory asserts `mem_ready` in its first cycle with `mem_rdata` = 0xDEADBEEF. Required: `mem_req` high in cycle 1 with `mem_addr` = 0x10 and `mem_we` = 0; `i_ack` = 1, `i_err` = 0, `i_rdata` = 0xDEADBEEF in cycle 2.
- **Simultaneous requests after reset.** Stimulus: `i_req` and `d_req` asserted (D is a store, addr 0x20, data 0x55) and held. Required: I is served first, then D with `mem_we` = 1, `mem_addr` = 0x20, `mem_wdata` = 0x55. `d_rdata` is unchanged.
- **Continuous contention over 6 transactions.** Required: grant order I, D, I, D, I, D, with exactly one IDLE cycle between transactions.
- **Timeout.** Stimulus: TIMEOUT = 4, `mem_ready` held at 0. Required: `mem_req` high for 4 cycles; `d_ack` = 1 with `d_err` = 1; `d_rdata` unchanged. Repeat with `mem_ready` = 1 in the 4th cycle: required `d_err` = 0 and data captured.
- **Reset mid-transaction.** Stimulus: assert `reset` low while BUSY_D. Required: `mem_req` = 0 immediately, no `d_ack`, and after release the first tie goes to I.
- **Stale request.** Stimulus: hold `i_req` high through its ack. Required: no re-grant in the ack cycle; a new I transaction starts one cycle later.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and port-select constants for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

endpackage

// File: rtl/arb_timeout.sv
// rtl/arb_timeout.sv - per-transaction wait counter that flags when TIMEOUT busy cycles are used up
module arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The last allowed busy cycle is the one where count sits at TIMEOUT-1.
    assign expired = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between fetch and load/store ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic                  i_err,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    logic last_d, last_d_nxt;
    logic tmo_clr, tmo_inc, tmo_expired;
    logic i_elig, d_elig;

    logic                  mem_req_nxt, mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;
    logic [DATA_WIDTH-1:0] i_rdata_nxt, d_rdata_nxt;

    arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    // A requester still holding req in its own ack cycle is a stale request.
    assign i_elig = i_req && !i_ack;
    assign d_elig = d_req && !d_ack;

    always_comb begin
        state_nxt     = state;
        last_d_nxt    = last_d;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_ack_nxt     = 1'b0;
        i_err_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_ack_nxt     = 1'b0;
        d_err_nxt     = 1'b0;
        d_rdata_nxt   = d_rdata;
        tmo_clr       = 1'b0;
        tmo_inc       = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (i_elig && (!d_elig || last_d == ARB_PORT_D)) begin
                    state_nxt     = ARB_BUSY_I;
                    last_d_nxt    = ARB_PORT_I;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = i_addr;
                    mem_wdata_nxt = '0;
                    tmo_clr       = 1'b1;
                end else if (d_elig) begin
                    state_nxt     = ARB_BUSY_D;
                    last_d_nxt    = ARB_PORT_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    tmo_clr       = 1'b1;
                end
            end
            ARB_BUSY_I: begin
                if (mem_ready) begin
                    state_nxt   = ARB_IDLE;
                    mem_req_nxt = 1'b0;
                    i_ack_nxt   = 1'b1;
                    i_rdata_nxt = mem_rdata;
                end else if (tmo_expired) begin
                    state_nxt   = ARB_IDLE;
                    mem_req_nxt = 1'b0;
                    i_ack_nxt   = 1'b1;
                    i_err_nxt   = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ARB_BUSY_D: begin
                if (mem_ready) begin
                    state_nxt   = ARB_IDLE;
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end else if (tmo_expired) begin
                    state_nxt   = ARB_IDLE;
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    d_err_nxt   = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: begin
                state_nxt   = ARB_IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            last_d    <= ARB_PORT_D;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            last_d    <= last_d_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ack     <= i_ack_nxt;
            i_err     <= i_err_nxt;
            i_rdata   <= i_rdata_nxt;
            d_ack     <= d_ack_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;

        // single fetch
        i_req = 1; i_addr = 32'h10; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("f1_mem_req", mem_req, 1);
        chk("f1_mem_addr", mem_addr, 32'h10);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_i_ack_early", i_ack, 0);
        tick();
        chk("f1_i_ack", i_ack, 1);
        chk("f1_i_err", i_err, 0);
        chk("f1_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f1_mem_req_drop", mem_req, 0);
        i_req = 0; mem_ready = 0;
        tick();
        chk("f1_i_ack_pulse", i_ack, 0);

        // simultaneous requests after reset: I first, then D store
        reset = 0; tick(); reset = 1;
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
        mem_ready = 1; mem_rdata = 32'h12345678;
        tick();
        chk("sim_i_addr", mem_addr, 32'h14);
        chk("sim_i_we", mem_we, 0);
        tick();
        chk("sim_i_ack", i_ack, 1);
        chk("sim_i_rdata", i_rdata, 32'h12345678);
        chk("sim_d_ack_not_yet", d_ack, 0);
        i_req = 0;
        tick();
        chk("sim_d_req", mem_req, 1);
        chk("sim_d_we", mem_we, 1);
        chk("sim_d_addr", mem_addr, 32'h20);
        chk("sim_d_wdata", mem_wdata, 32'h55);
        tick();
        chk("sim_d_ack", d_ack, 1);
        chk("sim_d_err", d_err, 0);
        chk("sim_d_rdata_held", d_rdata, 0);
        d_req = 0; d_we = 0;
        tick();

        // continuous contention: I, D, I, D, I, D with one idle cycle between
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_addr = 32'h30;
        mem_ready = 1;
        for (int k = 0; k < 6; k++) begin
            mem_rdata = 32'h100 + k;
            tick();
            chk("rr_mem_req", mem_req, 1);
            chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h40 : 32'h30);
            tick();
            chk("rr_idle", mem_req, 0);
            chk("rr_i_ack", i_ack, (k % 2 == 0) ? 1 : 0);
            chk("rr_d_ack", d_ack, (k % 2 == 0) ? 0 : 1);
            if (k % 2 == 1) chk("rr_d_rdata", d_rdata, 32'h100 + k);
        end
        i_req = 0; d_req = 0; mem_ready = 0;
        tick();

        // timeout with mem_ready held low
        d_req = 1; d_we = 0; d_addr = 32'h50;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("to_mem_req_hi", mem_req, 1);
            chk("to_no_ack", d_ack, 0);
        end
        tick();
        chk("to_d_ack", d_ack, 1);
        chk("to_d_err", d_err, 1);
        chk("to_d_rdata_held", d_rdata, 32'h105);
        chk("to_mem_req_lo", mem_req, 0);
        d_req = 0;
        tick();
        chk("to_ack_pulse", d_ack, 0);

        // ready in the last allowed cycle wins over the timeout
        d_req = 1; d_addr = 32'h54;
        tick(); tick(); tick(); tick();
        mem_ready = 1; mem_rdata = 32'hCAFE0004;
        tick();
        chk("tr_d_ack", d_ack, 1);
        chk("tr_d_err", d_err, 0);
        chk("tr_d_rdata", d_rdata, 32'hCAFE0004);
        d_req = 0; mem_ready = 0;
        tick();

        // reset in the middle of a data transaction
        d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h77;
        tick();
        chk("mr_busy", mem_req, 1);
        tick();
        reset = 0;
        #1;
        chk("mr_req_drop_async", mem_req, 0);
        tick();
        chk("mr_no_ack", d_ack, 0);
        reset = 1;
        i_req = 1; i_addr = 32'h70;
        d_we = 0; d_addr = 32'h74;
        tick();
        chk("mr_tie_addr", mem_addr, 32'h70);
        chk("mr_tie_we", mem_we, 0);
        chk("mr_tie_no_d_ack", d_ack, 0);
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("mr_i_ack", i_ack, 1);
        i_req = 0;
        tick();
        chk("mr_d_addr", mem_addr, 32'h74);
        tick();
        chk("mr_d_ack", d_ack, 1);
        chk("mr_d_rdata", d_rdata, 32'h0BAD_F00D);
        d_req = 0; mem_ready = 0;
        tick();

        // stale request held through its ack, then dropped mid-transaction
        i_req = 1; i_addr = 32'h80; mem_ready = 1; mem_rdata = 32'h11;
        tick();
        chk("st_req", mem_req, 1);
        tick();
        chk("st_ack", i_ack, 1);
        chk("st_idle", mem_req, 0);
        tick();
        chk("st_no_regrant", mem_req, 0);
        chk("st_ack_pulse", i_ack, 0);
        tick();
        chk("st_regrant", mem_req, 1);
        chk("st_regrant_addr", mem_addr, 32'h80);
        i_req = 0; mem_rdata = 32'h22;
        tick();
        chk("st_drop_ack", i_ack, 1);
        chk("st_drop_rdata", i_rdata, 32'h22);
        mem_ready = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
